// File: rtl/bldcm_period2freq_pkg.sv
// Shared types and width helper for the commutation-period to frequency converter.
package bldcm_period2freq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } p2f_state_t;

    // Bits needed to hold x, plus one guard bit so the divider's shifted remainder stays in W bits.
    function automatic int mf_bldcm_clog2(input longint unsigned x);
        int              n;
        longint unsigned v;
        n = 0;
        v = x;
        while (v != 0) begin
            v = v >> 1;
            n = n + 1;
        end
        return n + 1;
    endfunction

endpackage

// File: rtl/bldcm_udiv_seq.sv
// Iterative restoring divider: one quotient bit per clock, W clocks per result.
module bldcm_udiv_seq
    import bldcm_period2freq_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         iClock,
    input  logic         iReset_n,
    input  logic         abort_i,
    input  logic         start_i,
    input  logic [W-1:0] numer_i,
    input  logic [W-1:0] denom_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quot_o
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quot_q;
    logic [W-1:0]  denom_q;
    logic [CW-1:0] iter_q;
    logic          busy_q;
    logic          done_q;

    logic [W:0]    rem_sh;
    logic [W-1:0]  rem_sub;
    logic          fits;

    always_comb begin
        rem_sh  = {rem_q, quot_q[W-1]};
        // Only used when the divisor fits, where the true difference is below denom.
        rem_sub = rem_sh[W-1:0] - denom_q;
        fits    = (rem_sh >= {1'b0, denom_q});
    end

    always_ff @(posedge iClock) begin
        if (!iReset_n || abort_i) begin
            rem_q   <= '0;
            quot_q  <= '0;
            denom_q <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q   <= '0;
                quot_q  <= numer_i;
                denom_q <= denom_i;
                iter_q  <= '0;
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                rem_q  <= fits ? rem_sub : rem_sh[W-1:0];
                quot_q <= {quot_q[W-2:0], fits};
                if (iter_q == CW'(W - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    iter_q <= iter_q + 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quot_o = quot_q;

endmodule

// File: rtl/bldcm_period2freq.sv
// Measures motor electrical frequency from commutation-step strobes: freq = (clock/steps) / period.
module bldcm_period2freq
    import bldcm_period2freq_pkg::*;
#(
    parameter logic [31:0] pFreqClock        = 32'd50000000,
    parameter logic [2:0]  pTotalPhaseStages = 3'd6,
    parameter logic [31:0] pTimeoutClocks    = pFreqClock / {29'd0, pTotalPhaseStages}
) (
    input  logic        iClock,
    input  logic        iReset_n,
    input  logic        iStep,
    input  logic        iClear,
    output logic [31:0] oFreq,
    output logic        oFreqUpdate,
    output logic        oStopped,
    output logic        oBusy
);

    localparam logic [31:0]  NUM     = pFreqClock / {29'd0, pTotalPhaseStages};
    localparam int           W       = mf_bldcm_clog2(64'(NUM) + 64'd1);
    localparam logic [W-1:0] NUM_W   = NUM[W-1:0];
    localparam logic [W:0]   TIMEOUT = pTimeoutClocks[W:0];

    p2f_state_t   state_q;
    logic         armed_q;
    logic [W-1:0] cnt_q;
    logic         pend_q;
    logic [W-1:0] pend_period_q;
    logic [W-1:0] freq_q;
    logic         upd_q;
    logic         stopped_q;

    logic [W:0]   cnt_inc;
    logic [W-1:0] period_d;
    logic         timeout;
    logic         meas_step;
    logic         div_start;
    logic [W-1:0] div_denom;
    logic         div_abort;
    logic         div_busy;
    logic         div_done;
    logic [W-1:0] div_quot;

    always_comb begin
        cnt_inc   = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
        period_d  = cnt_inc[W-1:0];
        timeout   = armed_q && (cnt_inc == TIMEOUT);
        meas_step = iStep && armed_q && !timeout;
        div_start = 1'b0;
        div_denom = period_d;
        // A fresh step beats the stored pending period: only the newest measurement matters.
        if (!timeout) begin
            case (state_q)
                ST_IDLE: div_start = meas_step;
                ST_DONE: begin
                    div_start = meas_step || pend_q;
                    if (!meas_step) div_denom = pend_period_q;
                end
                default: div_start = 1'b0;
            endcase
        end
        div_abort = iClear || timeout;
    end

    always_ff @(posedge iClock) begin
        if (!iReset_n || iClear) begin
            state_q       <= ST_IDLE;
            armed_q       <= 1'b0;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            pend_period_q <= '0;
            freq_q        <= '0;
            upd_q         <= 1'b0;
            stopped_q     <= 1'b1;
        end else begin
            upd_q <= 1'b0;
            cnt_q <= iStep ? '0 : ((&cnt_q) ? cnt_q : cnt_inc[W-1:0]);
            if (timeout) begin
                // A step landing on the timeout cycle re-arms instead of measuring.
                armed_q   <= iStep;
                freq_q    <= '0;
                stopped_q <= 1'b1;
                upd_q     <= 1'b1;
                pend_q    <= 1'b0;
                state_q   <= ST_IDLE;
            end else begin
                if (iStep) armed_q <= 1'b1;
                case (state_q)
                    ST_IDLE: begin
                        if (div_start) state_q <= ST_DIV;
                    end
                    ST_DIV: begin
                        if (meas_step) begin
                            pend_q        <= 1'b1;
                            pend_period_q <= period_d;
                        end
                        if (div_done) begin
                            state_q   <= ST_DONE;
                            freq_q    <= div_quot;
                            stopped_q <= 1'b0;
                            upd_q     <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        pend_q  <= 1'b0;
                        state_q <= div_start ? ST_DIV : ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    bldcm_udiv_seq #(
        .W(W)
    ) u_div (
        .iClock  (iClock),
        .iReset_n(iReset_n),
        .abort_i (div_abort),
        .start_i (div_start),
        .numer_i (NUM_W),
        .denom_i (div_denom),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quot_o  (div_quot)
    );

    assign oFreq       = {{(32 - W){1'b0}}, freq_q};
    assign oFreqUpdate = upd_q;
    assign oStopped    = stopped_q;
    assign oBusy       = div_busy;

endmodule
